// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline slice: access-size encodings,
// memory control bundle and the datapath width legality check.
package pipe_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
        logic MemRead;
        logic MemWrite;
    } mem_ctrl_t;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational access aligner: flags misaligned/illegal sizes, builds the
// shifted byte-lane mask and moves store data into its byte lane.
module mem_align
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN / 8
) (
    input  logic [XLEN-1:0] addr,
    input  logic [1:0]      size,
    input  logic [XLEN-1:0] data,
    output logic            mis,
    output logic [BE_W-1:0] mask,
    output logic [XLEN-1:0] data_shifted
);

    localparam int OFF_W = $clog2(BE_W);

    logic [OFF_W-1:0] off;
    logic [7:0]       base_mask;
    logic [BE_W-1:0]  base_mask_w;

    assign off = addr[OFF_W-1:0];

    always_comb begin
        mis       = 1'b0;
        base_mask = 8'h01;
        case (size)
            SZ_B: begin
                mis       = 1'b0;
                base_mask = 8'h01;
            end
            SZ_H: begin
                mis       = addr[0];
                base_mask = 8'h03;
            end
            SZ_W: begin
                mis       = |addr[1:0];
                base_mask = 8'h0F;
            end
            default: begin
                // Doubleword accesses do not exist on a 32-bit datapath.
                mis       = (XLEN == 32) || (|addr[2:0]);
                base_mask = 8'hFF;
            end
        endcase
    end

    assign base_mask_w  = base_mask[BE_W-1:0];
    assign mask         = base_mask_w << off;
    assign data_shifted = data << {off, 3'b000};

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: valid tracking, stall/flush priority, gated
// memory control and byte-lane aligned store data, one cycle of latency.
module ex_mem_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int BE_W   = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   ALUResult_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    output logic              valid_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [2:0]        funct3_o,
    output logic [XLEN-1:0]   ALUResult_o,
    output logic [XLEN-1:0]   MemData_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              misaligned_o,
    output logic              fwd_en_o
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("ex_mem_pipe: XLEN must be 32 or 64");
    end

    logic              mis;
    logic [BE_W-1:0]   mask;
    logic [XLEN-1:0]   data_shifted;

    mem_align #(
        .XLEN (XLEN),
        .BE_W (BE_W)
    ) u_mem_align (
        .addr         (ALUResult_i),
        .size         (funct3_i[1:0]),
        .data         (rs2_data_i),
        .mis          (mis),
        .mask         (mask),
        .data_shifted (data_shifted)
    );

    logic              valid_reg, valid_next;
    mem_ctrl_t         ctrl_reg, ctrl_next;
    logic [2:0]        funct3_reg;
    logic [XLEN-1:0]   alu_reg;
    logic [XLEN-1:0]   data_reg;
    logic [BE_W-1:0]   be_reg, be_next;
    logic [REG_AW-1:0] rd_reg;
    logic              mis_reg, mis_next;
    logic              mis_acc;

    // Misalignment only matters for instructions that touch memory.
    assign mis_acc = (MemRead_i | MemWrite_i) & mis;

    always_comb begin
        valid_next         = valid_i;
        ctrl_next.RegWrite = valid_i & RegWrite_i & (rd_addr_i != '0) & ~mis_acc;
        ctrl_next.MemToReg = valid_i & MemToReg_i;
        ctrl_next.MemRead  = valid_i & MemRead_i & ~mis_acc;
        ctrl_next.MemWrite = valid_i & MemWrite_i & ~mis_acc;
        mis_next           = valid_i & mis_acc;
        be_next            = ctrl_next.MemWrite ? mask : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_reg  <= 1'b0;
            ctrl_reg   <= '0;
            funct3_reg <= '0;
            alu_reg    <= '0;
            data_reg   <= '0;
            be_reg     <= '0;
            rd_reg     <= '0;
            mis_reg    <= 1'b0;
        end else if (flush_i) begin
            // Bubble: data fields are left stale on purpose.
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            be_reg    <= '0;
            mis_reg   <= 1'b0;
        end else if (!stall_i) begin
            valid_reg  <= valid_next;
            ctrl_reg   <= ctrl_next;
            funct3_reg <= funct3_i;
            alu_reg    <= ALUResult_i;
            data_reg   <= data_shifted;
            be_reg     <= be_next;
            rd_reg     <= rd_addr_i;
            mis_reg    <= mis_next;
        end
    end

    assign valid_o      = valid_reg;
    assign RegWrite_o   = ctrl_reg.RegWrite;
    assign MemToReg_o   = ctrl_reg.MemToReg;
    assign MemRead_o    = ctrl_reg.MemRead;
    assign MemWrite_o   = ctrl_reg.MemWrite;
    assign funct3_o     = funct3_reg;
    assign ALUResult_o  = alu_reg;
    assign MemData_o    = data_reg;
    assign mem_be_o     = be_reg;
    assign rd_addr_o    = rd_reg;
    assign misaligned_o = mis_reg;
    assign fwd_en_o     = valid_reg & ctrl_reg.RegWrite & (rd_reg != '0);

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline register for the five-stage core, sitting between the ALU stage and data memory. Adds per-stage valid tracking, stall/flush control, store byte-lane alignment and byte-enable generation, misalignment detection and a forwarding tap. It replaces the fixed 32-bit, control-only EX/MEM latch and has one cycle of latency.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- REG_AW, 5: register-file address width.
- BE_W, XLEN/8: byte-enable width (derived; do not override).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold the current contents.
- flush_i  in  1  replace the contents with a bubble.
- valid_i  in  1  the EX-stage instruction is real.
- RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i  in  1 each  control bits from EX.
- funct3_i  in  3  access size/sign: [1:0] size (0=B, 1=H, 2=W, 3=D), [2] unsigned.
- ALUResult_i  in  XLEN  ALU result or effective address.
- rs2_data_i  in  XLEN  raw store data.
- rd_addr_i  in  REG_AW  destination register.
- valid_o  out  1  the MEM-stage instruction is real.
- RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o  out  1 each  registered control, gated as below.
- funct3_o  out  3  registered funct3.
- ALUResult_o  out  XLEN  registered address/result.
- MemData_o  out  XLEN  store data shifted into its byte lane.
- mem_be_o  out  BE_W  byte enables; zero unless MemWrite_o=1.
- rd_addr_o  out  REG_AW  registered destination register.
- misaligned_o  out  1  the registered access is misaligned or illegal.
- fwd_en_o  out  1  equals valid_o & RegWrite_o & (rd_addr_o != 0).

## Operation
- Update priority: rst_i > flush_i > stall_i > load.
- Load: capture all inputs and compute the derived fields, which are then registered.
- Flush: valid_o=0 and all control outputs 0; data fields may keep stale values.
- Stall: every output holds its value.
- Control gating at load:
  - RegWrite_o = valid_i & RegWrite_i & (rd_addr_i != 0).
  - MemRead_o = valid_i & MemRead_i & ~mis.
  - MemWrite_o = valid_i & MemWrite_i & ~mis.
- Misalignment (mis), evaluated only when MemRead_i|MemWrite_i, with addr = ALUResult_i:
  - H: addr[0] != 0.
  - W: addr[1:0] != 0.
  - D: addr[2:0] != 0, or XLEN=32 (size 3 is illegal at 32 bits).
- misaligned_o = valid_i & mem access & mis. On a misaligned access RegWrite_o is also forced to 0.
- Byte offset off = addr[log2(BE_W)-1:0].
- Byte enables: base mask B=1, H=3, W=0xF, D=0xFF, shifted left by off; mem_be_o = MemWrite_o ? mask : 0.
- Store data: MemData_o = rs2_data_i << (8*off), truncated to XLEN.
- funct3[2] is passed through only (load extension happens in MEM/WB).

## Timing
- Latency 1 cycle; no combinational input-to-output path.
- Reset value of every output is 0, including valid_o, misaligned_o, mem_be_o and fwd_en_o.
- Reset asserted mid-stall discards the held instruction immediately (asynchronous).
- Simultaneous flush_i and stall_i: flush wins and a bubble is inserted.
- Stall released: the next edge loads whatever is at the inputs; upstream must hold EX steady during the stall.
- Boundary cases:
  - rd_addr_i=0 with RegWrite_i=1 gives RegWrite_o=0 but still stores rd_addr_o=0.
  - An aligned D access at XLEN=64 with off=0 gives mem_be_o=0xFF.

## Structure
- Shared package pipe_pkg holds the funct3 size encodings (SZ_B/H/W/D), a mem_ctrl_t struct {RegWrite, MemToReg, MemRead, MemWrite}, and the XLEN legality check.
- One sub-module, mem_align: purely combinational, taking addr, size, XLEN and rs2 and producing mis, mask and shifted data. It is reused later by the load-side extractor.
- The top level holds only the registers and the priority logic.

## Test plan
- Reset then load: load sw, addr 0x1004, rs2 0xDEADBEEF, rd 0 → MemWrite_o=1, mem_be_o=0xF, MemData_o=0xDEADBEEF, fwd_en_o=0.
- Byte/half lanes: sb at addr 0x1003, rs2 0x000000AB → mem_be_o=0x8, MemData_o=0xAB000000. sh at addr 0x1002 → mem_be_o=0xC.
- Misaligned: lw at addr 0x1002 → misaligned_o=1, MemRead_o=0, RegWrite_o=0, valid_o=1. At XLEN=32, an sd at an aligned address → misaligned_o=1.
- Stall/flush: load add rd=5, then stall 3 cycles with the inputs changing → outputs unchanged. Assert stall and flush together → valid_o=0, RegWrite_o=0 on the next edge.
- Async reset: assert rst_i between edges while valid_o=1 → all outputs 0 before the next edge.
- XLEN=64 sd: addr 0x2000, rs2 0x0123456789ABCDEF → mem_be_o=0xFF, data unchanged. sw at 0x2004 → mem_be_o=0xF0, MemData_o=0x89ABCDEF00000000.
